// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR result serializer.
package fir_pkg;

    localparam int LANES = 16;
    localparam int DW    = 24;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Lane index width; a single-lane build still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_result_serializer_if.sv
// Frame input and serialized sample stream of the FIR result serializer.
interface fir_result_serializer_if #(
    parameter int LANES = fir_pkg::LANES,
    parameter int DW    = fir_pkg::DW
);

    logic                valid_core;
    logic [LANES*DW-1:0] in_data;
    logic [DW-1:0]       dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;

    modport master (
        input  valid_core, in_data, dout_ready,
        output dout, dout_valid, dout_last
    );

    modport slave (
        output valid_core, in_data, dout_ready,
        input  dout, dout_valid, dout_last
    );

endinterface

// File: rtl/fir_frame_buf.sv
// Two-slot frame store with write/read pointers and occupancy tracking.
module fir_frame_buf import fir_pkg::*; #(
    parameter int LANES = fir_pkg::LANES,
    parameter int DW    = fir_pkg::DW,
    localparam int IW   = idx_w(LANES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic                rd_done,
    input  logic [IW-1:0]       rd_idx,
    output logic [DW-1:0]       rd_data,
    output logic [1:0]          occ,
    output logic [1:0]          occ_nxt,
    output logic                drop
);

    logic [LANES*DW-1:0] slot [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic                accept;

    // A slot freed by the final beat this cycle can take a new frame.
    assign accept = wr_en && !clr && ((occ != 2'd2) || rd_done);
    assign drop   = wr_en && !clr && (occ == 2'd2) && !rd_done;

    always_comb begin
        occ_nxt = occ;
        if (accept && !rd_done)
            occ_nxt = occ + 2'd1;
        else if (!accept && rd_done)
            occ_nxt = occ - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (accept)  wr_ptr <= ~wr_ptr;
            if (rd_done) rd_ptr <= ~rd_ptr;
            occ <= occ_nxt;
        end
    end

    // Storage is never read before written: output is masked until SEND.
    always_ff @(posedge clk) begin
        if (accept) slot[wr_ptr] <= wr_data;
    end

    assign rd_data = slot[rd_ptr][int'(rd_idx)*DW +: DW];

endmodule

// File: rtl/fir_result_serializer.sv
// Buffers full lane frames and streams them out one sample per beat.
module fir_result_serializer import fir_pkg::*; #(
    parameter int LANES = fir_pkg::LANES,
    parameter int DW    = fir_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tc_set,
    fir_result_serializer_if.master  bus,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);

    localparam int            IW       = idx_w(LANES);
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    ser_state_e    state, state_nxt;
    logic [IW-1:0] idx;
    logic [DW-1:0] lane_data;
    logic [1:0]    occ, occ_nxt;
    logic          drop;
    logic          sending, last_beat, xfer, last_xfer;

    assign sending   = (state == SEND);
    assign last_beat = sending && (idx == LAST_IDX);
    assign xfer      = sending && bus.dout_ready;
    assign last_xfer = xfer && last_beat;

    fir_frame_buf #(.LANES(LANES), .DW(DW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tc_set),
        .wr_en   (bus.valid_core),
        .wr_data (bus.in_data),
        .rd_done (last_xfer),
        .rd_idx  (idx),
        .rd_data (lane_data),
        .occ     (occ),
        .occ_nxt (occ_nxt),
        .drop    (drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.dout       = '0;
        bus.dout_valid = 1'b0;
        bus.dout_last  = 1'b0;
        case (state)
            IDLE: if (occ != 2'd0) state_nxt = SEND;
            SEND: begin
                bus.dout       = lane_data;
                bus.dout_valid = 1'b1;
                bus.dout_last  = last_beat;
                // Stay in SEND across frames so the next lane 1 follows with no bubble.
                if (last_xfer && (occ_nxt == 2'd0)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (tc_set) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            overflow  <= 1'b0;
            frame_cnt <= 16'd0;
        end else if (tc_set) begin
            idx       <= '0;
            overflow  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            if (xfer)      idx       <= last_beat ? '0 : idx + 1'b1;
            if (drop)      overflow  <= 1'b1;
            if (last_xfer) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fir_result_serializer.sv
// Directed bench for fir_result_serializer: ordering, stalls, overflow, flush, reset, counter wrap.
module tb_fir_result_serializer;

    localparam int L  = 16;
    localparam int W  = 24;
    localparam int FW = L * W;

    logic        clk;
    logic        rst_n;
    logic        tc_set;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic        w_tc;
    logic        w_overflow;
    logic [15:0] w_frame_cnt;

    int nvec = 0;
    int nmis = 0;

    fir_result_serializer_if #(.LANES(L), .DW(W)) sif ();
    fir_result_serializer_if #(.LANES(1), .DW(8)) wif ();

    fir_result_serializer #(.LANES(L), .DW(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tc_set    (tc_set),
        .bus       (sif),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    fir_result_serializer #(.LANES(1), .DW(8)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .tc_set    (w_tc),
        .bus       (wif),
        .overflow  (w_overflow),
        .frame_cnt (w_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [23:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < L; i++) f[i*W +: W] = base + 24'(i);
        return f;
    endfunction

    task automatic send_frame(input logic [23:0] base);
        sif.valid_core = 1'b1;
        sif.in_data    = mk_frame(base);
        tick();
        sif.valid_core = 1'b0;
    endtask

    // Drain one frame, checking each beat; toggle=1 alternates ready to force stalls.
    task automatic recv_frame(input logic [23:0] base, input bit toggle, input string tag);
        int          k = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [23:0] held = '0;
        logic        rdy;
        while (k < L && cyc < 200) begin
            if (stalled) begin
                chk({tag, "_hold"}, 32'(sif.dout), 32'(held));
                chk({tag, "_hold_vld"}, 32'(sif.dout_valid), 32'd1);
                stalled = 1'b0;
            end
            rdy = toggle ? cyc[0] : 1'b1;
            sif.dout_ready = rdy;
            if (sif.dout_valid) begin
                chk({tag, "_data"}, 32'(sif.dout), 32'(base) + 32'(k));
                chk({tag, "_last"}, 32'(sif.dout_last), (k == L - 1) ? 32'd1 : 32'd0);
                if (rdy) k++;
                else begin
                    stalled = 1'b1;
                    held    = sif.dout;
                end
            end
            tick();
            cyc++;
        end
        chk({tag, "_beats"}, 32'(k), 32'(L));
        sif.dout_ready = 1'b0;
    endtask

    initial begin
        int w_sent;
        int w_emit;
        int cyc;
        bit seen_ffff;

        rst_n          = 1'b1;
        tc_set         = 1'b0;
        w_tc           = 1'b0;
        sif.valid_core = 1'b0;
        sif.in_data    = '0;
        sif.dout_ready = 1'b0;
        wif.valid_core = 1'b0;
        wif.in_data    = '0;
        wif.dout_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_dout", 32'(sif.dout), 32'd0);
        chk("rst_vld", 32'(sif.dout_valid), 32'd0);
        chk("rst_last", 32'(sif.dout_last), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, latency and ordering
        sif.dout_ready = 1'b1;
        send_frame(24'h000001);
        chk("t1_lat_n", 32'(sif.dout_valid), 32'd0);
        tick();
        chk("t1_lat_n1", 32'(sif.dout_valid), 32'd1);
        recv_frame(24'h000001, 1'b0, "t1");
        chk("t1_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_idle", 32'(sif.dout_valid), 32'd0);

        // Ready toggling every cycle
        send_frame(24'h000100);
        recv_frame(24'h000100, 1'b1, "t2");
        chk("t2_cnt", 32'(frame_cnt), 32'd2);

        // Overflow: A, B kept, C dropped
        send_frame(24'h000010);
        send_frame(24'h000020);
        chk("t3_ovf0", 32'(overflow), 32'd0);
        send_frame(24'h000030);
        chk("t3_ovf1", 32'(overflow), 32'd1);
        recv_frame(24'h000010, 1'b0, "t3a");
        chk("t3_nobub_vld", 32'(sif.dout_valid), 32'd1);
        chk("t3_nobub_dat", 32'(sif.dout), 32'h20);
        recv_frame(24'h000020, 1'b0, "t3b");
        chk("t3_cnt", 32'(frame_cnt), 32'd4);
        chk("t3_c_gone", 32'(sif.dout_valid), 32'd0);
        chk("t3_ovf_stk", 32'(overflow), 32'd1);
        tc_set = 1'b1;
        tick();
        tc_set = 1'b0;
        chk("t3_tc_ovf", 32'(overflow), 32'd0);
        chk("t3_tc_cnt", 32'(frame_cnt), 32'd0);

        // Full buffer, new frame coincident with last beat of A
        send_frame(24'h000040);
        send_frame(24'h000050);
        sif.dout_ready = 1'b1;
        for (int i = 0; i < L - 1; i++) begin
            chk("t4_a_data", 32'(sif.dout), 32'h40 + 32'(i));
            tick();
        end
        chk("t4_a_last", 32'(sif.dout_last), 32'd1);
        sif.valid_core = 1'b1;
        sif.in_data    = mk_frame(24'h000060);
        tick();
        sif.valid_core = 1'b0;
        sif.dout_ready = 1'b0;
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_b_first", 32'(sif.dout), 32'h50);
        recv_frame(24'h000050, 1'b0, "t4b");
        chk("t4_d_first", 32'(sif.dout), 32'h60);
        recv_frame(24'h000060, 1'b0, "t4d");
        chk("t4_cnt", 32'(frame_cnt), 32'd3);
        chk("t4_ovf_end", 32'(overflow), 32'd0);

        // Reset at beat 7 with buffer full and overflow set
        send_frame(24'h000080);
        send_frame(24'h000090);
        send_frame(24'h0000A0);
        chk("t6_ovf_pre", 32'(overflow), 32'd1);
        sif.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_beat7", 32'(sif.dout), 32'h86);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_dout", 32'(sif.dout), 32'd0);
        chk("t6_vld", 32'(sif.dout_valid), 32'd0);
        chk("t6_last", 32'(sif.dout_last), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_empty", 32'(sif.dout_valid), 32'd0);
        end
        send_frame(24'h0000B0);
        recv_frame(24'h0000B0, 1'b0, "t6j");
        chk("t6_cnt_post", 32'(frame_cnt), 32'd1);

        // tc_set wins over a coincident valid_core and flushes a full buffer
        send_frame(24'h0000C0);
        send_frame(24'h0000D0);
        sif.valid_core = 1'b1;
        sif.in_data    = mk_frame(24'h0000E0);
        tc_set         = 1'b1;
        tick();
        sif.valid_core = 1'b0;
        tc_set         = 1'b0;
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_vld", 32'(sif.dout_valid), 32'd0);
        chk("t5_cnt", 32'(frame_cnt), 32'd0);
        tick();
        chk("t5_dropped", 32'(sif.dout_valid), 32'd0);
        send_frame(24'h0000F0);
        recv_frame(24'h0000F0, 1'b0, "t5l");

        // frame_cnt wrap on a single-lane instance, one frame per cycle
        w_sent    = 0;
        w_emit    = 0;
        cyc       = 0;
        seen_ffff = 1'b0;
        while (w_emit < 65536 && cyc < 70000) begin
            wif.valid_core = (w_sent < 65536);
            wif.in_data    = 8'(w_sent);
            if (wif.valid_core) w_sent++;
            if (wif.dout_valid) begin
                if (w_emit < 4) chk("wrap_data", 32'(wif.dout), 32'(w_emit));
                w_emit++;
            end
            tick();
            cyc++;
            if (w_emit == 65535 && !seen_ffff) begin
                chk("wrap_ffff", 32'(w_frame_cnt), 32'hFFFF);
                seen_ffff = 1'b1;
            end
        end
        wif.valid_core = 1'b0;
        chk("wrap_frames", 32'(w_emit), 32'd65536);
        chk("wrap_zero", 32'(w_frame_cnt), 32'd0);
        chk("wrap_ovf", 32'(w_overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
